hdmi_delay_tuner: RTL and testbench
===================================

HDMI_DELAY_TUNER -- requirements
Module: hdmi_delay_tuner

Interface
REQ-001 SHALL have parameter ADVANCE, default 4'd0, fixed feedback-delay nibble driven on delay[7:4].
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024, clocks waited after each tap change before measuring (1..65535).
REQ-003 SHALL have parameter WINDOW_CYCLES, default 4096, clocks per measurement window (1..65535).
REQ-004 SHALL have parameter MIN_SCORE, default 16, minimum best score for a pass.
REQ-005 SHALL have port clk  in  1  pixel-domain clock; the only clock.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port pll_locked  in  1  PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port symbol_valid  in  1  one decoded TMDS symbol present this cycle.
REQ-009 SHALL have port symbol_err  in  1  qualified by symbol_valid; symbol not in the legal TMDS set.
REQ-010 SHALL have port start  in  1  single-cycle request to begin a sweep.
REQ-011 SHALL have port delay  out  8  PLL DYNAMICDELAY: [7:4]=ADVANCE, [3:0]=relative tap.
REQ-012 SHALL have port busy  out  1  sweep in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse at sweep end.
REQ-014 SHALL have port fail  out  1  level; last sweep best_score < MIN_SCORE.
REQ-015 SHALL have port best_tap  out  4  winning relative tap of last sweep.
REQ-016 SHALL have port best_score  out  16  good-symbol count at best_tap.

Function
REQ-017 SHALL pass pll_locked through a two-flop synchronizer; only the synchronized value (lock_s) is used.
REQ-018 SHALL implement states IDLE, WAIT_LOCK, SETTLE, MEASURE, NEXT, FINISH.
REQ-019 IDLE: start=1 -> tap=0, running max cleared, WAIT_LOCK; busy=1 in every state except IDLE.
REQ-020 WAIT_LOCK: lock_s=1 -> SETTLE with settle counter cleared.
REQ-021 SETTLE: after exactly SETTLE_CYCLES clocks with lock_s=1 -> MEASURE with window and score counters cleared.
REQ-022 MEASURE: score increments on each cycle with symbol_valid=1 and symbol_err=0, saturating at 16'hFFFF; after exactly WINDOW_CYCLES clocks -> NEXT.
REQ-023 NEXT (one clock): if score > running max (strictly), record tap and score; tap=15 -> FINISH, else tap+1 -> WAIT_LOCK; ties keep the lower tap.
REQ-024 lock_s=0 in SETTLE or MEASURE SHALL discard the partial count and return to WAIT_LOCK at the same tap.
REQ-025 FINISH (one clock): best_tap/best_score update, fail=(max<MIN_SCORE), done=1 for that clock, delay[3:0] := best_tap on pass or 4'd0 on fail; -> IDLE.
REQ-026 delay[3:0] SHALL equal the current sweep tap from the clock after entering WAIT_LOCK until FINISH; in IDLE it holds the last applied value.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Tap counter SHALL be 4 bits; no wrap beyond 15 occurs (FINISH taken at 15).
REQ-029 Sweep duration with steady lock SHALL be 16*(SETTLE_CYCLES+WINDOW_CYCLES+2)+1 clocks from start to done.

Reset
REQ-030 reset=1 SHALL force IDLE, delay={ADVANCE,4'd0}, busy=0, done=0, fail=0, best_tap=0, best_score=0, all counters and synchronizer flops 0; reset mid-sweep aborts with no done pulse.

Structure
REQ-031 State encoding and the 16-bit score width SHALL live in shared package hdmi_tuner_pkg.
REQ-032 Window counting and saturating scoring SHALL be one sub-module, hdmi_tap_scorer (clear, enable, symbol inputs -> score, window_end).

Verification (SETTLE_CYCLES=8, WINDOW_CYCLES=32, MIN_SCORE=16)
REQ-033 Lock steady, errors on all taps except 6..9 (clean) -> best_tap=6, best_score=32, fail=0, delay=8'h06, done at clock 673.
REQ-034 symbol_err=1 always -> best_score=0, fail=1, delay[3:0]=0.
REQ-035 pll_locked drops for 3 clocks mid-MEASURE at tap 4 -> tap 4 re-measured from WAIT_LOCK, final result unchanged vs. REQ-033.
REQ-036 start pulsed again during sweep -> ignored, single done pulse.
REQ-037 reset asserted at tap 10 -> next clock busy=0, delay=8'h00, no done; fresh start sweeps normally.
REQ-038 Clean symbols on taps 3 and 12 only, equal scores -> best_tap=3.

Source files
------------

// File: rtl/hdmi_tuner_pkg.sv
// Shared types for the HDMI PLL feedback-delay tuner: controller state encoding,
// score width and the saturating score increment.
package hdmi_tuner_pkg;

    localparam int SCORE_W = 16;
    localparam int TAP_W   = 4;
    localparam int CNT_W   = 16;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [TAP_W-1:0]   tap_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_MEASURE,
        ST_NEXT,
        ST_FINISH
    } tuner_state_t;

    localparam tap_t LAST_TAP = '1;

    function automatic score_t score_sat_inc(input score_t s);
        return (s == '1) ? s : s + score_t'(1);
    endfunction

endpackage

// File: rtl/hdmi_tap_scorer.sv
// Measurement window for one tap: counts WINDOW_CYCLES enabled clocks and the
// number of good (valid, non-error) TMDS symbols seen in them, saturating.
module hdmi_tap_scorer
    import hdmi_tuner_pkg::*;
#(
    parameter int WINDOW_CYCLES = 4096
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_clear,
    input  logic   i_enable,
    input  logic   i_symbol_valid,
    input  logic   i_symbol_err,
    output score_t o_score,
    output logic   o_window_end
);

    localparam cnt_t WIN_LAST = cnt_t'(WINDOW_CYCLES - 1);

    cnt_t   r_win_cnt;
    score_t r_score;
    logic   w_good;

    assign w_good = i_symbol_valid & ~i_symbol_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_score   <= '0;
        end else if (i_clear) begin
            r_win_cnt <= '0;
            r_score   <= '0;
        end else if (i_enable) begin
            r_win_cnt <= r_win_cnt + cnt_t'(1);
            if (w_good) begin
                r_score <= score_sat_inc(r_score);
            end
        end
    end

    // The final clock of the window still scores; its count lands with the edge that leaves MEASURE.
    assign o_window_end = i_enable && (r_win_cnt == WIN_LAST);
    assign o_score      = r_score;

endmodule

// File: rtl/hdmi_delay_tuner.sv
// Sweeps the 16 relative feedback-delay taps of the HDMI PLL, scores each tap by
// good TMDS symbols per window and applies the lowest best-scoring tap.
module hdmi_delay_tuner
    import hdmi_tuner_pkg::*;
#(
    parameter logic [3:0] ADVANCE       = 4'd0,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         WINDOW_CYCLES = 4096,
    parameter int         MIN_SCORE     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pll_locked,
    input  logic        symbol_valid,
    input  logic        symbol_err,
    input  logic        start,
    output logic [7:0]  delay,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [3:0]  best_tap,
    output logic [15:0] best_score
);

    localparam cnt_t   SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);
    localparam score_t MIN_SCORE_S = score_t'(MIN_SCORE);

    tuner_state_t r_state;
    tuner_state_t w_state_next;

    logic [1:0] r_lock_sync;
    logic       w_lock_s;

    tap_t   r_tap;
    tap_t   r_max_tap;
    score_t r_max;
    cnt_t   r_settle_cnt;
    tap_t   r_delay_lo;
    tap_t   r_best_tap;
    score_t r_best_score;
    logic   r_fail;

    logic   w_settle_done;
    logic   w_scorer_clear;
    logic   w_scorer_en;
    score_t w_score;
    logic   w_window_end;
    logic   w_better;
    score_t w_final_max;
    tap_t   w_final_tap;
    logic   w_final_fail;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_locked};
        end
    end

    assign w_lock_s = r_lock_sync[1];

    hdmi_tap_scorer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_scorer (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_scorer_clear),
        .i_enable       (w_scorer_en),
        .i_symbol_valid (symbol_valid),
        .i_symbol_err   (symbol_err),
        .o_score        (w_score),
        .o_window_end   (w_window_end)
    );

    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);

    // Strict comparison: on a tie the earlier (lower) tap keeps the win.
    assign w_better     = (w_score > r_max);
    assign w_final_max  = w_better ? w_score : r_max;
    assign w_final_tap  = w_better ? r_tap : r_max_tap;
    assign w_final_fail = (w_final_max < MIN_SCORE_S);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_scorer_clear = 1'b0;
        w_scorer_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (w_settle_done) begin
                    w_state_next   = ST_MEASURE;
                    w_scorer_clear = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else begin
                    w_scorer_en = 1'b1;
                    if (w_window_end) begin
                        w_state_next = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                w_state_next = (r_tap == LAST_TAP) ? ST_FINISH : ST_WAIT_LOCK;
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap        <= '0;
            r_max_tap    <= '0;
            r_max        <= '0;
            r_settle_cnt <= '0;
            r_delay_lo   <= '0;
            r_best_tap   <= '0;
            r_best_score <= '0;
            r_fail       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tap     <= '0;
                        r_max_tap <= '0;
                        r_max     <= '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    r_delay_lo   <= r_tap;
                    r_settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (w_lock_s && !w_settle_done) begin
                        r_settle_cnt <= r_settle_cnt + cnt_t'(1);
                    end
                end
                ST_NEXT: begin
                    r_max     <= w_final_max;
                    r_max_tap <= w_final_tap;
                    if (r_tap != LAST_TAP) begin
                        r_tap <= r_tap + tap_t'(1);
                    end else begin
                        // Results land on the edge into FINISH so they are valid alongside done.
                        r_best_tap   <= w_final_tap;
                        r_best_score <= w_final_max;
                        r_fail       <= w_final_fail;
                        r_delay_lo   <= w_final_fail ? tap_t'(0) : w_final_tap;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign delay      = {ADVANCE, r_delay_lo};
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);
    assign fail       = r_fail;
    assign best_tap   = r_best_tap;
    assign best_score = r_best_score;

endmodule

// File: tb/tb_hdmi_delay_tuner.sv
// Directed bench for hdmi_delay_tuner: symbol quality is a function of the applied
// tap, a sweep-level model predicts busy/done/delay every cycle and the final result.
module tb_hdmi_delay_tuner;

    localparam int         S       = 8;
    localparam int         W       = 32;
    localparam int         MIN     = 16;
    localparam logic [3:0] ADV     = 4'd0;
    localparam int         PER_TAP = S + W + 2;
    // Cycles after the start-sampling edge at which done is high (captured by the next edge).
    localparam int         DONE_N  = 16 * PER_TAP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pll_locked = 1'b1;
    logic        symbol_valid = 1'b0;
    logic        symbol_err = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  delay;
    logic        busy;
    logic        done;
    logic        fail;
    logic [3:0]  best_tap;
    logic [15:0] best_score;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_mask;
    bit          m_alt;
    bit          m_timed;
    bit          m_active;
    int          m_n;
    logic [3:0]  m_idle_lo;
    logic [3:0]  m_res_lo;
    int          m_res_tap;
    int          m_res_score;
    bit          m_res_fail;
    bit          alt_phase;

    always #5 clk = ~clk;

    hdmi_delay_tuner #(
        .ADVANCE       (ADV),
        .SETTLE_CYCLES (S),
        .WINDOW_CYCLES (W),
        .MIN_SCORE     (MIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .symbol_valid (symbol_valid),
        .symbol_err   (symbol_err),
        .start        (start),
        .delay        (delay),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .best_tap     (best_tap),
        .best_score   (best_score)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Each tap scores W good symbols if clean (W/2 when valid alternates), else 0.
    function automatic void model_best(input logic [15:0] mask, input bit alt,
                                       output int tap, output int score);
        int mx;
        int s;
        mx  = 0;
        tap = 0;
        for (int t = 0; t < 16; t++) begin
            s = mask[t] ? (alt ? W / 2 : W) : 0;
            if (s > mx) begin
                mx  = s;
                tap = t;
            end
        end
        score = mx;
    endfunction

    task automatic model_compare();
        forever begin
            @(posedge clk);
            if (reset) begin
                m_active  = 1'b0;
                m_idle_lo = 4'd0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_n      = 0;
                end
            end else if (m_timed && m_n == DONE_N) begin
                m_active  = 1'b0;
                m_idle_lo = m_res_lo;
            end else begin
                m_n++;
            end
            @(negedge clk);
            if (m_timed) begin
                chk("busy", 32'(busy), 32'(m_active));
                chk("done", 32'(done), 32'(m_active && m_n == DONE_N));
                if (!m_active) begin
                    chk("idle_delay", 32'(delay[3:0]), 32'(m_idle_lo));
                end else if (m_n >= 1 && m_n < DONE_N) begin
                    chk("sweep_tap", 32'(delay[3:0]), 32'((m_n - 1) / PER_TAP));
                end
            end
            chk("delay_hi", 32'(delay[7:4]), 32'(ADV));
        end
    endtask

    task automatic drive_symbols();
        forever begin
            @(negedge clk);
            alt_phase    = ~alt_phase;
            symbol_valid = m_alt ? alt_phase : 1'b1;
            symbol_err   = ~m_mask[delay[3:0]];
        end
    endtask

    task automatic do_sweep(input logic [15:0] mask, input bit alt, input bit timed,
                            input int extra_start_n, input int drop_n, input int reset_n,
                            output int done_clk, output int done_cnt);
        bit stop;
        int tail;
        m_mask  = mask;
        m_alt   = alt;
        m_timed = timed;
        model_best(mask, alt, m_res_tap, m_res_score);
        m_res_fail = (m_res_score < MIN);
        m_res_lo   = m_res_fail ? 4'd0 : 4'(m_res_tap);
        done_clk = -1;
        done_cnt = 0;
        stop     = 1'b0;
        tail     = 0;
        start    = 1'b1;
        for (int c = 0; c < 3000 && !stop; c++) begin
            @(negedge clk);
            start      = (m_active && m_n == extra_start_n);
            pll_locked = !(drop_n >= 0 && m_n >= drop_n && m_n < drop_n + 3);
            if (drop_n >= 0 && m_n == drop_n) begin
                chk("drop_at_tap4", 32'(delay[3:0]), 32'd4);
            end
            if (done) begin
                done_cnt++;
                if (done_clk < 0) done_clk = m_n + 1;
            end
            if (reset_n >= 0 && m_active && m_n == reset_n) begin
                chk("pre_reset_tap", 32'(delay[3:0]), 32'd10);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_delay", 32'(delay), 32'h00);
                chk("rst_done", 32'(done), 32'd0);
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                chk("rst_no_done", 32'(done_cnt), 32'd0);
                stop = 1'b1;
            end else if (done_clk >= 0) begin
                tail++;
                if (tail > 5) stop = 1'b1;
            end
        end
        start      = 1'b0;
        pll_locked = 1'b1;
        if (reset_n < 0 && done_clk < 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic check_results(input string pfx);
        chk({pfx, "_tap"},   32'(best_tap),   32'(m_res_tap));
        chk({pfx, "_score"}, 32'(best_score), 32'(m_res_score));
        chk({pfx, "_fail"},  32'(fail),       32'(m_res_fail));
        chk({pfx, "_delay"}, 32'(delay),      32'({ADV, m_res_lo}));
    endtask

    int dc;
    int dn;

    initial begin
        m_mask    = '0;
        m_alt     = 1'b0;
        m_timed   = 1'b1;
        m_active  = 1'b0;
        m_n       = 0;
        m_idle_lo = '0;
        m_res_lo  = '0;
        alt_phase = 1'b0;
        fork
            model_compare();
            drive_symbols();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_busy",  32'(busy),       32'd0);
        chk("reset_done",  32'(done),       32'd0);
        chk("reset_fail",  32'(fail),       32'd0);
        chk("reset_tap",   32'(best_tap),   32'd0);
        chk("reset_score", 32'(best_score), 32'd0);
        chk("reset_delay", 32'(delay),      32'h00);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Clean taps 6..9, with a stray start mid-sweep that must be ignored.
        do_sweep(16'h03C0, 1'b0, 1'b1, 300, -1, -1, dc, dn);
        chk("a_done_clk", 32'(dc), 32'd673);
        chk("a_done_cnt", 32'(dn), 32'd1);
        check_results("a");
        chk("a_lit_tap",   32'(best_tap),   32'd6);
        chk("a_lit_score", 32'(best_score), 32'd32);
        chk("a_lit_delay", 32'(delay),      32'h06);

        // Every symbol in error.
        do_sweep(16'h0000, 1'b0, 1'b1, -1, -1, -1, dc, dn);
        chk("b_done_clk", 32'(dc), 32'd673);
        check_results("b");
        chk("b_lit_score", 32'(best_score), 32'd0);
        chk("b_lit_fail",  32'(fail),       32'd1);
        chk("b_lit_delay", 32'(delay),      32'h00);

        // Lock drop for three clocks in the middle of tap 4's window.
        do_sweep(16'h03C0, 1'b0, 1'b0, -1, 4 * PER_TAP + 22, -1, dc, dn);
        chk("c_done_late", 32'(dc > 673), 32'd1);
        chk("c_done_cnt", 32'(dn), 32'd1);
        check_results("c");
        chk("c_lit_tap", 32'(best_tap), 32'd6);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        m_timed = 1'b1;
        repeat (5) @(negedge clk);

        // Reset while tap 10 is applied, then a fresh sweep.
        do_sweep(16'h03C0, 1'b0, 1'b1, -1, -1, 10 * PER_TAP + 5, dc, dn);
        chk("d_score_cleared", 32'(best_score), 32'd0);
        do_sweep(16'h03C0, 1'b0, 1'b1, -1, -1, -1, dc, dn);
        chk("d_done_clk", 32'(dc), 32'd673);
        check_results("d");

        // Equal scores on taps 3 and 12: lower tap wins.
        do_sweep(16'h1008, 1'b0, 1'b1, -1, -1, -1, dc, dn);
        check_results("e");
        chk("e_lit_tap",   32'(best_tap),   32'd3);
        chk("e_lit_score", 32'(best_score), 32'd32);

        // Half-rate symbols on tap 2: score lands exactly on MIN_SCORE and passes.
        do_sweep(16'h0004, 1'b1, 1'b1, -1, -1, -1, dc, dn);
        check_results("f");
        chk("f_lit_score", 32'(best_score), 32'd16);
        chk("f_lit_fail",  32'(fail),       32'd0);
        chk("f_lit_delay", 32'(delay),      32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
